pico_ctrl: RTL and testbench
============================

// Module: pico_ctrl
// PURPOSE
//  Instruction sequencer and decoder that drives the picoMips ALU control inputs.
//  - Fetches 16-bit words from a synchronous program ROM (1-cycle read latency).
//  - Decodes each word into Func/WE/SelSW/SelImm/UseMul/UseACC/Imm.
//  - Sequences the PC, including jumps, branch-on-zero and a wait-for-button handshake.
//  - Sits between program ROM and ALU; the ALU reports ACC==0 back via AccZero.
// PARAMETERS
//  PCW   6   PC / ROM address width; program space 2**PCW words
// PORTS
//  Clock    in   1    system clock, all state on posedge
//  Reset    in   1    synchronous, active-high
//  Instr    in   16   ROM data for address presented on PC in previous cycle
//  AccZero  in   1    ALU ACC == 0 (sampled in EXEC only)
//  Btn      in   1    asynchronous push button, active-high
//  PC       out  PCW  ROM read address
//  Imm      out  8    Instr[7:0] in EXEC, else 0
//  Func     out  3    Instr[15:13] in EXEC, else 0
//  WE       out  1    ALU accumulator write enable
//  SelSW    out  1    ALU operand = SW
//  SelImm   out  1    ALU operand = Imm
//  UseMul   out  1    ALU multiply mode
//  UseACC   out  1    ALU adds ACC into result
// BEHAVIOUR
//  Format: Instr[15:13]=op, [12:8] ignored, [7:0]=Imm (PC target = Imm[PCW-1:0]).
//  States: FETCH, EXEC, WAIT (2-bit reg). Reset -> FETCH, PC=0, sync flops=0.
//  FETCH: all control outputs 0; PC held (ROM reads it); next = EXEC.
//  EXEC: Instr valid; decode is combinational from Instr, gated by state==EXEC:
//   op  name   WE SelSW SelImm UseMul UseACC  next PC      next state
//   000 NOP    0  0     0      0      0       PC+1         FETCH
//   001 LDSW   1  1     0      0      0       PC+1         FETCH  ACC<=SW
//   010 ADDI   1  0     1      0      1       PC+1         FETCH  ACC<=ACC+Imm
//   011 ADDR   1  0     0      0      1       PC+1         FETCH  ACC<=ACC+Reg
//   100 MULI   1  0     1      1      1       PC+1         FETCH  ACC<=ACC*Imm
//   101 WAITB  0  0     0      0      0       PC (hold)    WAIT
//   110 JMP    0  0     0      0      0       Imm[PCW-1:0] FETCH
//   111 BEQZ   0  0     0      0      0       AccZero?Imm:PC+1  FETCH
//  WE high for exactly one cycle per ALU op; ALU captures on EXEC->FETCH edge.
//  Throughput: 2 cycles/instr; WAITB: 2 cycles + wait time + 1.
//  Btn: 2-flop synchroniser + previous-value flop; BtnRise = sync & ~prev.
//  WAIT: outputs 0; on BtnRise -> PC<=PC+1, FETCH; else stay. Rises outside
//   WAIT are discarded (not latched). Btn held high entering WAIT does not
//   release; a fresh 0->1 edge is required.
//  PC arithmetic modulo 2**PCW: PC+1 from all-ones wraps to 0; jump/branch
//   targets truncate Imm to PCW bits.
//  BEQZ samples AccZero in EXEC; a BEQZ directly after an ALU op sees
//   the updated ACC (ALU wrote at end of previous EXEC).
//  Reset in any state (incl. WAIT, or EXEC with WE=1): next cycle FETCH, PC=0,
//   all outputs 0; the WE pulse in the reset cycle is still seen by the ALU
//   (the ALU has no reset).
//  Outputs never X after first reset; unused Instr[12:8] never affect outputs.
// TESTING
//  1 Reset held 3 cycles, release: PC=0, all ctrl 0 in FETCH, EXEC after 1 cycle.
//  2 ROM {LDSW; ADDI 5; MULI 3}, SW=2 -> WE pulses at cycles 2,4,6; ALU ACC=2,7,21.
//  3 PCW=6, NOP at 63 -> PC goes 63 -> 0; JMP 0xC5 -> PC=5 (truncated).
//  4 WAITB at 4, Btn already high -> stays in WAIT; Btn 0 then 1 -> PC=5
//    within 4 cycles of the rise (2 sync + 1 + 1 FETCH); pulse during EXEC ignored.
//  5 BEQZ 9 with AccZero=1 -> PC=9; AccZero=0 -> PC=old+1; after ADDI -1 from
//    ACC=1, BEQZ taken.
//  6 Reset asserted in WAIT and in EXEC of MULI -> next cycle FETCH, PC=0,
//    WE=0; program re-runs identically from address 0.

Source files
------------

// File: rtl/pico_ctrl.sv
// picoMips instruction sequencer: fetches 16-bit words from a 1-cycle-latency ROM,
// decodes them into ALU control strobes and sequences the PC (jump, branch-on-zero, wait-for-button).
module pico_ctrl #(
    parameter int PCW = 6
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [15:0]    Instr,
    input  logic           AccZero,
    input  logic           Btn,
    output logic [PCW-1:0] PC,
    output logic [7:0]     Imm,
    output logic [2:0]     Func,
    output logic           WE,
    output logic           SelSW,
    output logic           SelImm,
    output logic           UseMul,
    output logic           UseACC
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LDSW  = 3'b001;
    localparam logic [2:0] OP_ADDI  = 3'b010;
    localparam logic [2:0] OP_ADDR  = 3'b011;
    localparam logic [2:0] OP_MULI  = 3'b100;
    localparam logic [2:0] OP_WAITB = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_BEQZ  = 3'b111;

    localparam logic [PCW-1:0] PC_ONE = PCW'(1);

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic           btn_meta_q, btn_sync_q, btn_prev_q;

    logic [2:0]     op;
    logic [PCW-1:0] pc_inc;
    logic [PCW-1:0] target;
    logic           btn_rise;
    logic           unused_instr_bits;

    assign op       = Instr[15:13];
    assign pc_inc   = pc_q + PC_ONE;
    assign target   = Instr[PCW-1:0];
    assign btn_rise = btn_sync_q & ~btn_prev_q;
    assign unused_instr_bits = ^Instr[12:8];

    // The previous-value flop tracks the button in every state, so an edge seen
    // outside WAIT is simply consumed and a button already held high never fires.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            btn_meta_q <= Btn;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_WAITB: begin
                        state_d = S_WAIT;
                        pc_d    = pc_q;
                    end
                    OP_JMP:  pc_d = target;
                    OP_BEQZ: pc_d = AccZero ? target : pc_inc;
                    default: pc_d = pc_inc;
                endcase
            end
            S_WAIT: begin
                if (btn_rise) begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Decode is not gated by Reset: a WE pulse in the reset cycle still reaches the ALU.
    always_comb begin
        Func   = '0;
        Imm    = '0;
        WE     = 1'b0;
        SelSW  = 1'b0;
        SelImm = 1'b0;
        UseMul = 1'b0;
        UseACC = 1'b0;
        if (state_q == S_EXEC) begin
            Func = op;
            Imm  = Instr[7:0];
            case (op)
                OP_LDSW: begin
                    WE    = 1'b1;
                    SelSW = 1'b1;
                end
                OP_ADDI: begin
                    WE     = 1'b1;
                    SelImm = 1'b1;
                    UseACC = 1'b1;
                end
                OP_ADDR: begin
                    WE     = 1'b1;
                    UseACC = 1'b1;
                end
                OP_MULI: begin
                    WE     = 1'b1;
                    SelImm = 1'b1;
                    UseMul = 1'b1;
                    UseACC = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign PC = pc_q;

endmodule

// File: tb/tb_pico_ctrl.sv
// Self-checking bench for pico_ctrl: decode/PC vector table plus ROM-driven
// sequences with a behavioural ALU for the multi-cycle corner cases.
module tb_pico_ctrl;

    localparam int PCW = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic [15:0]    instr;
    logic           az;
    logic           btn;
    logic [PCW-1:0] pc;
    logic [7:0]     imm;
    logic [2:0]     func;
    logic           we, sel_sw, sel_imm, use_mul, use_acc;

    always #5 clk = ~clk;

    pico_ctrl #(.PCW(PCW)) dut (
        .Clock  (clk),
        .Reset  (rst),
        .Instr  (instr),
        .AccZero(az),
        .Btn    (btn),
        .PC     (pc),
        .Imm    (imm),
        .Func   (func),
        .WE     (we),
        .SelSW  (sel_sw),
        .SelImm (sel_imm),
        .UseMul (use_mul),
        .UseACC (use_acc)
    );

    // Instruction/AccZero come either from the ROM + ALU models or straight from the stimulus.
    logic        rom_mode;
    logic [15:0] drv_instr;
    logic        drv_az;
    logic [15:0] rom [64];
    logic [15:0] rom_q;
    logic [7:0]  acc, sw, reg_val, opnd, alu_res;
    logic [15:0] ctrl;

    always @(posedge clk) rom_q <= rom[pc];

    always_comb begin
        opnd    = sel_sw ? sw : (sel_imm ? imm : reg_val);
        alu_res = use_mul ? 8'(acc * opnd) : 8'((use_acc ? acc : 8'd0) + opnd);
    end

    always @(posedge clk) if (we) acc <= alu_res;

    assign instr = rom_mode ? rom_q : drv_instr;
    assign az    = rom_mode ? (acc == 8'd0) : drv_az;
    assign ctrl  = {func, imm, we, sel_sw, sel_imm, use_mul, use_acc};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Holds reset for n rising edges; returns at the falling edge where it is released (cycle 1, FETCH).
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    endtask

    // Expected trace of the LDSW / MULI 3 / WAITB program, cycles 1..7 after reset release.
    task automatic check_trace(input string tag, input int upto);
        logic [PCW-1:0] exp_pc [7];
        logic           exp_we [7];
        exp_pc = '{6'd0, 6'd0, 6'd1, 6'd1, 6'd2, 6'd2, 6'd2};
        exp_we = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int c = 1; c <= upto; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("%s_pc_c%0d", tag, c), 32'(pc), 32'(exp_pc[c-1]));
            check($sformatf("%s_we_c%0d", tag, c), 32'(we), 32'(exp_we[c-1]));
        end
    endtask

    typedef struct {
        logic [15:0]    instr;
        logic           az;
        logic [2:0]     func;
        logic [7:0]     imm;
        logic [4:0]     sig;   // {WE, SelSW, SelImm, UseMul, UseACC}
        logic [PCW-1:0] pc;    // PC after the instruction completes
    } vec_t;

    vec_t vecs [13];
    vec_t exp_q [$];
    logic [7:0]     exp_acc [$];
    logic [PCW-1:0] exp_pcq [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t           e;
        logic [7:0]     we_mask;
        logic           prev_we;
        logic           found;
        int             lat;

        rst       = 1'b0;
        btn       = 1'b0;
        rom_mode  = 1'b1;
        drv_instr = 16'h0000;
        drv_az    = 1'b0;
        sw        = 8'd2;
        reg_val   = 8'd4;
        clear_rom();

        // Reset state, first fetch/exec, and the LDSW / ADDI 5 / MULI 3 program.
        rom[0] = 16'h2000;
        rom[1] = 16'h4005;
        rom[2] = 16'h8003;
        rom[3] = 16'hC003;
        exp_acc.push_back(8'd2);
        exp_acc.push_back(8'd7);
        exp_acc.push_back(8'd21);
        do_reset(3);
        check("t1_reset_pc", 32'(pc), 32'd0);
        check("t1_fetch_ctrl", 32'(ctrl), 32'd0);
        we_mask = '0;
        prev_we = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            if (prev_we && exp_acc.size() > 0) check($sformatf("t2_acc_c%0d", c), 32'(acc), 32'(exp_acc.pop_front()));
            if (c == 2) check("t1_exec_ldsw", 32'(ctrl), 32'({3'd1, 8'h00, 5'b11000}));
            we_mask[c] = we;
            prev_we    = we;
        end
        check("t2_we_cycles", 32'(we_mask), 32'h54);
        check("t2_acc_queue_empty", 32'(exp_acc.size()), 32'd0);

        // Decode/PC table, instructions driven directly in FETCH.
        vecs[0]  = '{16'h0000, 1'b0, 3'd0, 8'h00, 5'b00000, 6'd1};
        vecs[1]  = '{16'h2011, 1'b0, 3'd1, 8'h11, 5'b11000, 6'd2};
        vecs[2]  = '{16'h4005, 1'b0, 3'd2, 8'h05, 5'b10101, 6'd3};
        vecs[3]  = '{16'h6000, 1'b0, 3'd3, 8'h00, 5'b10001, 6'd4};
        vecs[4]  = '{16'h8003, 1'b0, 3'd4, 8'h03, 5'b10111, 6'd5};
        vecs[5]  = '{16'hC02A, 1'b0, 3'd6, 8'h2A, 5'b00000, 6'd42};
        vecs[6]  = '{16'hE010, 1'b1, 3'd7, 8'h10, 5'b00000, 6'd16};
        vecs[7]  = '{16'hE030, 1'b0, 3'd7, 8'h30, 5'b00000, 6'd17};
        vecs[8]  = '{16'h1F00, 1'b1, 3'd0, 8'h00, 5'b00000, 6'd18};
        vecs[9]  = '{16'h5F7F, 1'b0, 3'd2, 8'h7F, 5'b10101, 6'd19};
        vecs[10] = '{16'hE0FF, 1'b1, 3'd7, 8'hFF, 5'b00000, 6'd63};
        vecs[11] = '{16'h0000, 1'b0, 3'd0, 8'h00, 5'b00000, 6'd0};
        vecs[12] = '{16'hC0C5, 1'b0, 3'd6, 8'hC5, 5'b00000, 6'd5};
        rom_mode = 1'b0;
        do_reset(2);
        for (int i = 0; i < 13; i++) begin
            drv_instr = vecs[i].instr;
            drv_az    = vecs[i].az;
            exp_q.push_back(vecs[i]);
            #1;
            check($sformatf("tbl%0d_fetch_idle", i), 32'(ctrl), 32'd0);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("tbl%0d_decode", i), 32'(ctrl), 32'({e.func, e.imm, e.sig}));
            @(negedge clk);
            check($sformatf("tbl%0d_next_pc", i), 32'(pc), 32'(e.pc));
        end
        rom_mode = 1'b1;

        // Wait-for-button: held-high button, falling edge, fresh rise, rise during EXEC.
        clear_rom();
        rom[4] = 16'hA0AB;
        rom[6] = 16'hA000;
        btn = 1'b1;
        do_reset(2);
        repeat (9) @(negedge clk);
        check("t4_waitb_decode", 32'(ctrl), 32'({3'd5, 8'hAB, 5'b00000}));
        repeat (9) @(negedge clk);
        check("t4_held_btn_pc", 32'(pc), 32'd4);
        check("t4_wait_ctrl", 32'(ctrl), 32'd0);
        btn = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_fall_no_release", 32'(pc), 32'd4);
        btn = 1'b1;
        found = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 6 && !found; k++) begin
            @(negedge clk);
            if (pc == 6'd5) begin
                found = 1'b1;
                lat   = k;
            end
        end
        check("t4_release_found", 32'(found), 32'd1);
        check("t4_release_within_4", 32'(lat >= 1 && lat <= 4), 32'd1);
        btn = 1'b0;
        @(negedge clk);
        btn = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_exec_waitb_align", 32'(func), 32'd5);
        repeat (8) @(negedge clk);
        check("t4_exec_rise_ignored", 32'(pc), 32'd6);
        btn = 1'b0;
        repeat (4) @(negedge clk);
        btn = 1'b1;
        found = 1'b0;
        for (int k = 1; k <= 4 && !found; k++) begin
            @(negedge clk);
            if (pc == 6'd7) found = 1'b1;
        end
        check("t4_second_release", 32'(found), 32'd1);
        btn = 1'b0;

        // Branch-on-zero right after ALU ops, taken and not taken.
        clear_rom();
        sw      = 8'd1;
        rom[0]  = 16'h2000;
        rom[1]  = 16'h40FF;
        rom[2]  = 16'hE009;
        rom[9]  = 16'h4003;
        rom[10] = 16'hE01E;
        rom[11] = 16'hC00B;
        exp_pcq = '{6'd0, 6'd1, 6'd2, 6'd9, 6'd10, 6'd11, 6'd11};
        do_reset(2);
        for (int j = 0; j < 7; j++) begin
            if (j > 0) repeat (2) @(negedge clk);
            check($sformatf("t5_fetch_pc%0d", j), 32'(pc), 32'(exp_pcq.pop_front()));
        end
        check("t5_acc", 32'(acc), 32'd3);

        // Reset taken in WAIT and in EXEC of MULI; program re-runs from address 0.
        clear_rom();
        sw     = 8'd2;
        rom[0] = 16'h2000;
        rom[1] = 16'h8003;
        rom[2] = 16'hA000;
        do_reset(2);
        check_trace("t6_run", 7);
        check("t6_acc_run", 32'(acc), 32'd6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_wait_reset_ctrl", 32'(ctrl), 32'd0);
        check_trace("t6_rerun", 4);
        check("t6_acc_before_reset", 32'(acc), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_exec_reset_we_seen", 32'(acc), 32'd6);
        check("t6_exec_reset_ctrl", 32'(ctrl), 32'd0);
        check_trace("t6_rerun2", 7);
        check("t6_acc_rerun2", 32'(acc), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
